// File: rtl/a2d_pkg.sv
// Shared types and divider/transaction constants for the A2D SPI master.
// Divider constants are generated from the divider width (5 bits gives 10111/01111/11111).
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TXN1,
    GAP,
    TXN2,
    BACK_PORCH
  } a2d_state_e;

  localparam int TXN_LEN = 16;

  // Front porch preload: SCLK high, 9 clks before the first (dummy) fall.
  function automatic logic [31:0] div_preload(input int w);
    return (32'd1 << (w - 1)) | ((32'd1 << (w - 2)) - 32'd1);
  endfunction

  function automatic logic [31:0] div_rise(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] div_fall(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/spi_shft16.sv
// 16-bit SPI shift register with MISO sample flop and falling-edge shift counter.
// The first shift request after a load/clear is the dummy edge: no shift, not counted.
module spi_shft16
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] cmd_i,
  input  logic        clear_i,
  input  logic        smpl_i,
  input  logic        shift_i,
  input  logic        miso_i,
  output logic        mosi_o,
  output logic [11:0] data_o,
  output logic        done_o
);

  logic [15:0] shft_q;
  logic        smpl_q;
  logic [4:0]  cnt_q;
  logic        dummy_q;

  // Asserted in the same cycle as the shift that completes the word.
  assign done_o = shift_i && !dummy_q && (cnt_q == 5'(TXN_LEN - 1));
  assign mosi_o = shft_q[15];
  assign data_o = shft_q[11:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shft_q  <= '0;
      smpl_q  <= 1'b0;
      cnt_q   <= '0;
      dummy_q <= 1'b1;
    end else begin
      if (smpl_i) smpl_q <= miso_i;
      if (load_i || clear_i) begin
        shft_q  <= load_i ? cmd_i : 16'h0000;
        cnt_q   <= '0;
        dummy_q <= 1'b1;
      end else if (shift_i) begin
        if (dummy_q) begin
          dummy_q <= 1'b0;
        end else begin
          shft_q <= {shft_q[14:0], smpl_q};
          cnt_q  <= cnt_q + 5'd1;
        end
      end
    end
  end

endmodule

// File: rtl/a2d_intf.sv
// SPI master for an ADC128S-style 8-channel 12-bit A2D: command frame, 1-clk gap, result frame.
// Build option: define A2D_RES_INVERT_EN to present the bit-inverted result.
module a2d_intf
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam logic [SCLK_DIV_W-1:0] DIV_PRELOAD = SCLK_DIV_W'(div_preload(SCLK_DIV_W));
  localparam logic [SCLK_DIV_W-1:0] DIV_RISE    = SCLK_DIV_W'(div_rise(SCLK_DIV_W));
  localparam logic [SCLK_DIV_W-1:0] DIV_FALL    = SCLK_DIV_W'(div_fall(SCLK_DIV_W));

  a2d_state_e            state_q;
  logic [SCLK_DIV_W-1:0] div_q, div_d;
  logic                  ss_n_q;
  logic                  cmplt_q;
  logic [11:0]           res_q;

  logic        active, smpl, shft, load, clear, done;
  logic [11:0] data;

  assign active = (state_q == TXN1) || (state_q == TXN2);
  assign smpl   = active && (div_q == DIV_RISE);
  assign shft   = active && (div_q == DIV_FALL);
  assign load   = (state_q == IDLE) && strt_cnv;
  assign clear  = (state_q == GAP);

  spi_shft16 u_shft (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .cmd_i  ({2'b00, chnnl, 11'h000}),
    .clear_i(clear),
    .smpl_i (smpl),
    .shift_i(shft),
    .miso_i (MISO),
    .mosi_o (MOSI),
    .data_o (data),
    .done_o (done)
  );

  // Divider sits at the preload whenever SPI is idle so SCLK rests high;
  // reloading on the last shift keeps SCLK high through GAP and BACK_PORCH.
  always_comb begin
    div_d = DIV_PRELOAD;
    unique case (state_q)
      TXN1, TXN2: if (!done) div_d = div_q + 1'b1;
      BACK_PORCH: if (div_q != DIV_FALL) div_d = div_q + 1'b1;
      default:    div_d = DIV_PRELOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ss_n_q  <= 1'b1;
      cmplt_q <= 1'b0;
      res_q   <= '0;
      div_q   <= DIV_PRELOAD;
    end else begin
      div_q   <= div_d;
      cmplt_q <= 1'b0;
      case (state_q)
        IDLE: if (strt_cnv) begin
          state_q <= TXN1;
          ss_n_q  <= 1'b0;
        end
        TXN1: if (done) begin
          state_q <= GAP;
          ss_n_q  <= 1'b1;
        end
        GAP: begin
          state_q <= TXN2;
          ss_n_q  <= 1'b0;
        end
        TXN2: if (done) state_q <= BACK_PORCH;
        BACK_PORCH: if (div_q == DIV_FALL) begin
          state_q <= IDLE;
          ss_n_q  <= 1'b1;
          cmplt_q <= 1'b1;
`ifdef A2D_RES_INVERT_EN
          res_q   <= ~data;
`else
          res_q   <= data;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign SCLK      = div_q[SCLK_DIV_W-1];
  assign SS_n      = ss_n_q;
  assign cnv_cmplt = cmplt_q;
  assign res       = res_q;

endmodule

// File: tb/tb_a2d_intf.sv
// Self-checking bench for a2d_intf: SPI slave model, result scoreboard, randomized traffic.
module tb_a2d_intf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strt_cnv = 1'b0;
  logic [2:0]  chnnl = 3'd0;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        SS_n, SCLK, MOSI;
  logic        MISO = 1'b0;

  a2d_intf dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .strt_cnv (strt_cnv),
    .chnnl    (chnnl),
    .cnv_cmplt(cnv_cmplt),
    .res      (res),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    ncmp++;
    if (act !== exp_v) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  function automatic logic [11:0] exp_val(input logic [11:0] v);
`ifdef A2D_RES_INVERT_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  // Stimulus-owned expectations
  logic [11:0] exp_arr [64];
  int          n_iss = 0;
  logic [11:0] slv_res = 12'h000;
  logic [15:0] exp_cmd = 16'h0000;
  int          lat0 = -1;

  // ---------------- SPI slave model ----------------
  int          rcnt = 0;
  int          fpar = 0;
  int          ss_rise_cyc = 0;
  int          last_rise = 0;
  logic [15:0] rx = 16'h0, txw = 16'h0, last_cmd = 16'h0;
  logic        ss_p = 1'b1, sclk_p = 1'b1;

  always @(SS_n or SCLK or rst_n) begin
    if (!rst_n) begin
      fpar = 0;
      rcnt = 0;
    end else if (ss_p === 1'b1 && SS_n === 1'b0) begin
      if (fpar == 1) chk("gap_clks", cyc - ss_rise_cyc, 1);
      rcnt = 0;
      rx   = 16'h0;
      txw  = (fpar == 1) ? {4'h0, slv_res} : 16'($urandom);
      MISO = txw[15];
    end else if (ss_p === 1'b0 && SS_n === 1'b1) begin
      chk("bits_per_frame", rcnt, 16);
      if (fpar == 0) begin
        chk("cmd_word", rx, exp_cmd);
        last_cmd    = rx;
        ss_rise_cyc = cyc;
      end
      fpar = 1 - fpar;
    end else if (SS_n === 1'b0 && sclk_p === 1'b0 && SCLK === 1'b1) begin
      if (rcnt > 0) chk("sclk_period", cyc - last_rise, 32);
      last_rise = cyc;
      rx = {rx[14:0], MOSI};
      rcnt++;
    end else if (SS_n === 1'b0 && sclk_p === 1'b1 && SCLK === 1'b0) begin
      if (rcnt > 0 && rcnt < 16) MISO = txw[15-rcnt];
    end
    ss_p   = SS_n;
    sclk_p = SCLK;
  end

  // ---------------- per-cycle compare ----------------
  logic [11:0] hold_res = 12'h000;
  logic        prev_c = 1'b0;
  int          n_done = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_res = 12'h000;
      prev_c   = 1'b0;
    end else begin
      if (SS_n) chk("sclk_idle_high", SCLK, 1'b1);
      if (cnv_cmplt) begin
        chk("cmplt_width", prev_c, 1'b0);
        if (n_done >= n_iss) begin
          ncmp++;
          nerr++;
          $display("FAIL spurious_cmplt: got cnv_cmplt=1, expected 0 (cycle %0d)", cyc);
        end else begin
          hold_res = exp_arr[n_done];
          n_done++;
          chk("res", res, hold_res);
        end
      end else begin
        chk("res_hold", res, hold_res);
      end
      prev_c = cnv_cmplt;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_conv(input logic [2:0] ch, input logic [11:0] v, input bit noise);
    int  t0, lat, noise_at;
    bit  seen;
    @(negedge clk);
    chnnl   = ch;
    slv_res = v;
    exp_cmd = {2'b00, ch, 11'h000};
    exp_arr[n_iss] = exp_val(v);
    n_iss++;
    strt_cnv = 1'b1;
    @(negedge clk);
    strt_cnv = 1'b0;
    t0 = cyc;
    noise_at = int'($urandom_range(3, 1000));
    seen = 1'b0;
    lat = 0;
    for (int k = 1; k < 3000 && !seen; k++) begin
      @(negedge clk);
      strt_cnv = (noise && k == noise_at) ? 1'b1 : 1'b0;
      if (noise && (k == noise_at || k == noise_at + 40)) chnnl = 3'($urandom);
      if (cnv_cmplt) begin
        seen = 1'b1;
        lat  = cyc - t0;
      end
    end
    strt_cnv = 1'b0;
    if (!seen) begin
      ncmp++;
      nerr++;
      $display("FAIL cmplt_timeout: got no cnv_cmplt, expected one within 3000 clks");
    end else if (lat0 < 0) begin
      lat0 = lat;
    end else begin
      chk("latency", lat, lat0);
    end
  endtask

  logic [2:0] seq [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  initial begin
    int base, k;
    repeat (5) @(negedge clk);
    chk("rst_SS_n", SS_n, 1'b1);
    chk("rst_SCLK", SCLK, 1'b1);
    chk("rst_MOSI", MOSI, 1'b0);
    chk("rst_cmplt", cnv_cmplt, 1'b0);
    chk("rst_res", res, 12'h000);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_no_cmplt", n_done, 0);
    chk("idle_res", res, 12'h000);

    // Directed: channel 5, slave returns A5C
    do_conv(3'd5, 12'hA5C, 1'b0);
    chk("cmd_2800", last_cmd, 16'h2800);
`ifdef A2D_RES_INVERT_EN
    chk("res_A5C", res, 12'h5A3);
`else
    chk("res_A5C", res, 12'hA5C);
`endif

    // Motion controller sequence, with stray strt_cnv/chnnl activity mid-conversion
    base = n_done;
    foreach (seq[i]) do_conv(seq[i], 12'h100 + {9'h0, seq[i]}, 1'b1);
    chk("b2b_count", n_done - base, 6);

    // Async reset during TXN1 bit 7
    @(negedge clk);
    chnnl = 3'd6;
    exp_cmd = {2'b00, 3'd6, 11'h000};
    strt_cnv = 1'b1;
    @(negedge clk);
    strt_cnv = 1'b0;
    k = 0;
    while (rcnt != 7 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("reach_bit7", (rcnt == 7) ? 1 : 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_SS_n", SS_n, 1'b1);
    chk("arst_SCLK", SCLK, 1'b1);
    chk("arst_res", res, 12'h000);
    chk("arst_MOSI", MOSI, 1'b0);
    base = n_done;
    repeat (3) begin
      @(negedge clk);
      chk("arst_hold_SCLK", SCLK, 1'b1);
      chk("arst_no_cmplt", cnv_cmplt, 1'b0);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_no_completion", n_done - base, 0);
    do_conv(3'd2, 12'h3FF, 1'b0);
    chk("res_3FF", res, exp_val(12'h3FF));

    // Full-scale then zero: no stale bits
    do_conv(3'd4, 12'hFFF, 1'b0);
`ifdef A2D_RES_INVERT_EN
    chk("res_FFF", res, 12'h000);
`else
    chk("res_FFF", res, 12'hFFF);
`endif
    do_conv(3'd1, 12'h000, 1'b0);
`ifdef A2D_RES_INVERT_EN
    chk("res_000", res, 12'hFFF);
`else
    chk("res_000", res, 12'h000);
`endif

    // Randomized conversions
    repeat (4) do_conv(3'($urandom), 12'($urandom), 1'b1);

    repeat (20) @(negedge clk);
    chk("completions", n_done, n_iss);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
